// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_hs_pkg
// Description : Shared types and helpers for the toggle-handshake CDC
//               transmitter. Provides the handshake state type and the
//               timeout-timer width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_hs_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_e;

    // The timer must be able to hold TOCYCLES itself (it saturates there).
    // A disabled timeout (TOCYCLES = 0) still yields a legal 1-bit width.
    function automatic int timer_width(input int tocycles);
        return (tocycles < 1) ? 1 : $clog2(tocycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Single-bit multi-flop synchronizer with synchronous
//               reset to 0.
//   clk   - destination clock
//   reset - synchronous, active-high reset; clears every stage
//   d     - asynchronous input bit
//   q     - synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int NUMSTGS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [NUMSTGS-1:0] r_chain;

    // Stage 0 is the only flop that samples the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUMSTGS-2:0], d};
        end
    end

    assign q = r_chain[NUMSTGS-1];

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source side of a 2-phase (toggle) req/ack bus crossing.
//               Accepts a word over valid/ready, holds it on xfer_data,
//               toggles xfer_req, and waits for the resynchronized
//               xfer_ack toggle before accepting the next word.
//   clk       - source-domain clock
//   reset     - synchronous, active-high reset
//   in_valid  - local word available
//   in_ready  - block can accept a word this cycle (state == IDLE)
//   in_data   - local word
//   xfer_data - registered bus, stable while a transfer is outstanding
//   xfer_req  - registered request toggle
//   xfer_ack  - asynchronous acknowledge toggle from the destination
//   busy      - transfer outstanding (state == WAIT_ACK)
//   timeout   - one-cycle pulse when the wait reaches TOCYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATAWTH  = 8,
    parameter int NUMSTGS  = 2,
    parameter int TOCYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATAWTH-1:0] in_data,
    output logic [DATAWTH-1:0] xfer_data,
    output logic               xfer_req,
    input  logic               xfer_ack,
    output logic               busy,
    output logic               timeout
);

    localparam int c_TMR_W = timer_width(TOCYCLES);

    hs_state_e          r_state;
    hs_state_e          w_state_nxt;
    logic               w_accept;
    logic               w_ack_s;
    logic [DATAWTH-1:0] r_xfer_data;
    logic               r_xfer_req;

    sync_bit #(
        .NUMSTGS (NUMSTGS)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (xfer_ack),
        .q     (w_ack_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion compares against the already-toggled req, so an ack edge
    // coinciding with acceptance can never complete the new transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_ack_s == r_xfer_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_data <= '0;
            r_xfer_req  <= 1'b0;
        end else if (w_accept) begin
            r_xfer_data <= in_data;
            r_xfer_req  <= ~r_xfer_req;
        end
    end

    generate
        if (TOCYCLES > 0) begin : g_timeout
            logic [c_TMR_W-1:0] r_timer;
            logic               r_timeout;

            // Timer saturates at TOCYCLES so the pulse fires only once per
            // transfer even if the wait continues indefinitely.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_timer   <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    r_timeout <= (r_state == WAIT_ACK) &&
                                 (r_timer == c_TMR_W'(TOCYCLES - 1));
                    if (w_accept) begin
                        r_timer <= '0;
                    end else if ((r_state == WAIT_ACK) &&
                                 (r_timer != c_TMR_W'(TOCYCLES))) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            end

            assign timeout = r_timeout;
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == WAIT_ACK);
    assign xfer_data = r_xfer_data;
    assign xfer_req  = r_xfer_req;

endmodule
`default_nettype wire
